// File: rtl/md5_pad_loader_if.sv
// md5_pad_loader_if: password byte stream in, MD5 core newtext/load/digest handshake and status out.
interface md5_pad_loader_if;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_data;
    logic         s_last;
    logic         md5_newtext_o;
    logic         md5_load_o;
    logic [127:0] md5_data_o;
    logic         md5_ready_i;
    logic [127:0] md5_data_i;
    logic [127:0] digest_o;
    logic         digest_valid_o;
    logic         err_o;
    logic         busy_o;
    modport slave (
        input  s_valid, s_data, s_last, md5_ready_i, md5_data_i,
        output s_ready, md5_newtext_o, md5_load_o, md5_data_o, digest_o, digest_valid_o, err_o, busy_o
    );
    modport master (
        output s_valid, s_data, s_last, md5_ready_i, md5_data_i,
        input  s_ready, md5_newtext_o, md5_load_o, md5_data_o, digest_o, digest_valid_o, err_o, busy_o
    );
endinterface

// File: rtl/md5_pad_loader.sv
// md5_pad_loader: builds one padded 512-bit MD5 block from a byte stream, loads it into the core, captures the digest.
// Define MD5_DIGEST_BYTESWAP_EN to byte-reverse each digest word into canonical MD5 byte order.
module md5_pad_loader #(
    parameter int MAX_LEN      = 55,
    parameter int WAIT_TIMEOUT = 127
) (
    input  logic clk,
    input  logic reset,
    md5_pad_loader_if.slave bus
);
    localparam int TW = $clog2(WAIT_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, PAD, NEWTEXT, LOAD, WAIT, ERR} state_t;
    state_t        state_q, state_d;
    logic [7:0]    mem [64];
    logic [5:0]    cnt_q;
    logic [1:0]    beat_q;
    logic [TW-1:0] timer_q;
    logic          s_ready_q;
    logic          dv_q;
    logic [127:0]  digest_q;
    logic [511:0]  blk;
    logic [127:0]  capture;
    logic [31:0]   bit_len;
    logic          acc;
    logic          full;
    assign acc     = bus.s_valid && s_ready_q;
    assign full    = cnt_q == 6'(MAX_LEN);
    assign bit_len = {23'd0, cnt_q, 3'd0};
    assign bus.s_ready        = s_ready_q;
    assign bus.digest_o       = digest_q;
    assign bus.digest_valid_o = dv_q;
    // byte i lands in word i/4, lane i%4 (lane 0 = word bits [7:0]); word 0 is the block MSBs
    always_comb begin
        blk = '0;
        for (int i = 0; i < 64; i++) blk[480 - 32 * (i / 4) + 8 * (i % 4) +: 8] = mem[i];
    end
`ifdef MD5_DIGEST_BYTESWAP_EN
    always_comb begin
        capture = '0;
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 4; b++) capture[32 * w + 8 * b +: 8] = bus.md5_data_i[32 * w + 24 - 8 * b +: 8];
    end
`else
    assign capture = bus.md5_data_i;
`endif
    always_ff @(posedge clk or negedge reset)
        if (!reset) state_q <= IDLE;
        else state_q <= state_d;
    always_comb begin
        state_d           = state_q;
        bus.md5_newtext_o = state_q == NEWTEXT;
        bus.md5_load_o    = state_q == LOAD;
        bus.md5_data_o    = state_q == LOAD ? blk[511 - 128 * int'(beat_q) -: 128] : '0;
        bus.err_o         = state_q == ERR;
        bus.busy_o        = state_q != IDLE;
        case (state_q)
            IDLE:    state_d = acc ? (bus.s_last ? PAD : COLLECT) : IDLE;
            COLLECT: if (acc) state_d = full ? (bus.s_last ? ERR : DRAIN) : (bus.s_last ? PAD : COLLECT);
            DRAIN:   if (acc && bus.s_last) state_d = ERR;
            PAD:     state_d = NEWTEXT;
            NEWTEXT: state_d = LOAD;
            LOAD:    if (beat_q == 2'd3) state_d = WAIT;
            WAIT:    state_d = bus.md5_ready_i ? IDLE : (timer_q >= TW'(WAIT_TIMEOUT - 1) ? ERR : WAIT);
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // timer holds cycles elapsed since the last load beat, so ERR lands exactly WAIT_TIMEOUT cycles later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            cnt_q     <= '0;
            beat_q    <= '0;
            timer_q   <= '0;
            s_ready_q <= 1'b0;
            dv_q      <= 1'b0;
            digest_q  <= '0;
        end else begin
            s_ready_q <= state_d inside {IDLE, COLLECT, DRAIN};
            dv_q      <= state_q == WAIT && bus.md5_ready_i;
            beat_q    <= state_q == LOAD ? beat_q + 2'd1 : 2'd0;
            timer_q   <= state_q == WAIT ? timer_q + 1'b1 : TW'(1);
            if (state_q == WAIT && bus.md5_ready_i) digest_q <= capture;
            if (state_q != IDLE && state_d == IDLE) begin
                for (int i = 0; i < 64; i++) mem[i] <= '0;
                cnt_q <= '0;
            end else if (acc && (state_q == IDLE || (state_q == COLLECT && !full))) begin
                mem[cnt_q] <= bus.s_data;
                cnt_q      <= cnt_q + 6'd1;
            end else if (state_q == PAD) begin
                mem[cnt_q] <= 8'h80;
                mem[56]    <= bit_len[7:0];
                mem[57]    <= bit_len[15:8];
                mem[58]    <= bit_len[23:16];
                mem[59]    <= bit_len[31:24];
            end
        end
    end
endmodule

// File: tb/tb_md5_pad_loader.sv
// tb_md5_pad_loader: scoreboard bench for md5_pad_loader with a scripted MD5 core.
module tb_md5_pad_loader;
    localparam logic [127:0] ABC_RAW = 128'h98500190_b04fd23c_7d3f96d6_727fe128;
    localparam logic [127:0] A_RAW   = 128'hb975c10c_a8b6f1c0_e299c331_61267769;
`ifdef MD5_DIGEST_BYTESWAP_EN
    localparam logic [127:0] ABC_DIG = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] A_DIG   = 128'h0cc175b9c0f1b6a831c399e269772661;
`else
    localparam logic [127:0] ABC_DIG = ABC_RAW;
    localparam logic [127:0] A_DIG   = A_RAW;
`endif
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    md5_pad_loader_if bus();
    md5_pad_loader dut (.clk(clk), .reset(reset), .bus(bus));
    int compared = 0;
    int mismatched = 0;
    logic [127:0] beat_q [$];
    logic [127:0] dig_q [$];
    logic [127:0] beats [4];
    logic [7:0] msg [64];
    int n_nt = 0, n_ld = 0, n_err = 0, n_dv = 0, run = 0;
    logic prev_nt = 1'b0, prev_ld = 1'b0;

    function automatic logic [127:0] exp_of(input logic [127:0] raw);
        logic [127:0] r;
        r = raw;
`ifdef MD5_DIGEST_BYTESWAP_EN
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 4; b++) r[32 * w + 8 * b +: 8] = raw[32 * w + 24 - 8 * b +: 8];
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            prev_nt = 1'b0;
            prev_ld = 1'b0;
            run = 0;
        end else begin
            if (bus.md5_newtext_o) n_nt++;
            if (bus.err_o) n_err++;
            if (bus.md5_newtext_o && bus.md5_load_o) begin
                compared++; mismatched++;
                $display("FAIL overlap: newtext=1 load=1, required never both");
            end
            if (bus.md5_load_o) begin
                logic [127:0] e;
                compared++;
                if (beat_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_load: got %h, required no load", bus.md5_data_o);
                end else begin
                    e = beat_q.pop_front();
                    if (bus.md5_data_o !== e) begin
                        mismatched++;
                        $display("FAIL beat: got %h required %h", bus.md5_data_o, e);
                    end
                end
                compared++;
                if (!(prev_nt || prev_ld)) begin
                    mismatched++;
                    $display("FAIL load_order: load without preceding newtext/load");
                end
                beats[run[1:0]] = bus.md5_data_o;
                run++;
                n_ld++;
            end else begin
                if (prev_ld) begin
                    compared++;
                    if (run != 4) begin
                        mismatched++;
                        $display("FAIL burst_len: got %0d beats required 4", run);
                    end
                end
                if (prev_nt) begin
                    compared++; mismatched++;
                    $display("FAIL newtext_then_load: load=0 after newtext, required 1");
                end
                if (bus.md5_data_o !== '0) begin
                    compared++; mismatched++;
                    $display("FAIL data_idle: got %h required 0", bus.md5_data_o);
                end
                run = 0;
            end
            if (bus.digest_valid_o) begin
                n_dv++;
                compared++;
                if (dig_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_dv: digest %h, required no pulse", bus.digest_o);
                end else begin
                    logic [127:0] d;
                    d = dig_q.pop_front();
                    if (bus.digest_o !== d) begin
                        mismatched++;
                        $display("FAIL digest_sb: got %h required %h", bus.digest_o, d);
                    end
                end
            end
            prev_nt = bus.md5_newtext_o;
            prev_ld = bus.md5_load_o;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic push_beats(input int len);
        logic [7:0] p [64];
        logic [511:0] b;
        logic [31:0] bl;
        for (int i = 0; i < 64; i++) p[i] = (i < len) ? msg[i] : 8'h00;
        p[len] = 8'h80;
        bl = 32'(len * 8);
        {p[59], p[58], p[57], p[56]} = bl;
        for (int k = 0; k < 16; k++) b[511 - 32 * k -: 32] = {p[4 * k + 3], p[4 * k + 2], p[4 * k + 1], p[4 * k]};
        for (int n = 0; n < 4; n++) beat_q.push_back(b[511 - 128 * n -: 128]);
    endtask

    task automatic send(input int len);
        for (int i = 0; i < len; i++) begin
            int w;
            bus.s_valid = 1'b1;
            bus.s_data  = msg[i];
            bus.s_last  = i == len - 1;
            w = 0;
            while (!bus.s_ready && w < 20) begin
                tick;
                w++;
            end
            compared++;
            if (bus.s_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL s_ready_stuck: byte %0d s_ready=%b required 1", i, bus.s_ready);
            end
            tick;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_loads(input int start);
        int w = 0;
        while (n_ld < start + 4 && w < 40) begin
            tick;
            w++;
        end
        compared++;
        if (n_ld != start + 4) begin
            mismatched++;
            $display("FAIL load_count: got %0d required %0d", n_ld - start, 4);
        end
    endtask

    task automatic respond(input logic [127:0] raw, input logic [127:0] exp, input int lat);
        repeat (lat) tick;
        bus.md5_ready_i = 1'b1;
        bus.md5_data_i  = raw;
        dig_q.push_back(exp);
        tick;
        bus.md5_ready_i = 1'b0;
        bus.md5_data_i  = '0;
        compared++;
        if (bus.digest_valid_o !== 1'b1) begin
            mismatched++;
            $display("FAIL dv_timing: digest_valid_o=%b required 1", bus.digest_valid_o);
        end
        compared++;
        if (bus.digest_o !== exp) begin
            mismatched++;
            $display("FAIL digest: got %h required %h", bus.digest_o, exp);
        end
        compared++;
        if (bus.busy_o !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_after: busy_o=%b required 0", bus.busy_o);
        end
        tick;
        compared++;
        if (bus.digest_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL dv_pulse: digest_valid_o=%b required 0", bus.digest_valid_o);
        end
    endtask

    task automatic run_abc;
        int nt0 = n_nt;
        int ld0 = n_ld;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        push_beats(3);
        send(3);
        compared++;
        if (bus.busy_o !== 1'b1 || bus.s_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL pad_state: busy=%b s_ready=%b required 1/0", bus.busy_o, bus.s_ready);
        end
        wait_loads(ld0);
        compared++;
        if (n_nt != nt0 + 1) begin
            mismatched++;
            $display("FAIL newtext_count: got %0d required 1", n_nt - nt0);
        end
        compared++;
        if (beats[0] !== 128'h80636261_00000000_00000000_00000000) begin
            mismatched++;
            $display("FAIL abc_beat0: got %h required 80636261000000000000000000000000", beats[0]);
        end
        compared++;
        if (beats[3] !== 128'h00000000_00000000_00000018_00000000) begin
            mismatched++;
            $display("FAIL abc_beat3: got %h required 00000000000000000000001800000000", beats[3]);
        end
        respond(ABC_RAW, ABC_DIG, 3);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) tick;
        compared++;
        if ({bus.s_ready, bus.md5_newtext_o, bus.md5_load_o, bus.digest_valid_o, bus.err_o, bus.busy_o} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b required 000000",
                {bus.s_ready, bus.md5_newtext_o, bus.md5_load_o, bus.digest_valid_o, bus.err_o, bus.busy_o});
        end
        compared++;
        if (bus.md5_data_o !== '0 || bus.digest_o !== '0) begin
            mismatched++;
            $display("FAIL reset_data: md5_data_o=%h digest_o=%h required 0", bus.md5_data_o, bus.digest_o);
        end
        reset = 1'b1;
        tick;
        compared++;
        if (bus.s_ready !== 1'b1 || bus.busy_o !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_after_reset: s_ready=%b busy=%b required 1/0", bus.s_ready, bus.busy_o);
        end
    endtask

    task automatic test_abc;
        run_abc();
    endtask

    task automatic test_one_byte;
        int ld0 = n_ld;
        int dv0;
        msg[0] = 8'h61;
        push_beats(1);
        send(1);
        wait_loads(ld0);
        compared++;
        if (beats[0][127:96] !== 32'h00008061) begin
            mismatched++;
            $display("FAIL a_word0: got %h required 00008061", beats[0][127:96]);
        end
        compared++;
        if (beats[3][63:32] !== 32'h00000008) begin
            mismatched++;
            $display("FAIL a_word14: got %h required 00000008", beats[3][63:32]);
        end
        respond(A_RAW, A_DIG, 1);
        dv0 = n_dv;
        bus.md5_ready_i = 1'b1;
        bus.md5_data_i  = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        tick;
        bus.md5_ready_i = 1'b0;
        bus.md5_data_i  = '0;
        tick;
        compared++;
        if (bus.digest_o !== A_DIG || n_dv != dv0 || bus.busy_o !== 1'b0) begin
            mismatched++;
            $display("FAIL ready_in_idle: digest=%h dv=%0d busy=%b required %h 0 0", bus.digest_o, n_dv - dv0, bus.busy_o, A_DIG);
        end
    endtask

    task automatic test_max_len;
        int ld0 = n_ld;
        int err0 = n_err;
        for (int i = 0; i < 55; i++) msg[i] = 8'h41;
        push_beats(55);
        send(55);
        wait_loads(ld0);
        compared++;
        if (beats[3][95:64] !== 32'h80414141) begin
            mismatched++;
            $display("FAIL max_word13: got %h required 80414141", beats[3][95:64]);
        end
        compared++;
        if (beats[3][63:32] !== 32'h000001B8) begin
            mismatched++;
            $display("FAIL max_word14: got %h required 000001b8", beats[3][63:32]);
        end
        respond(128'h01234567_89abcdef_fedcba98_76543210, exp_of(128'h01234567_89abcdef_fedcba98_76543210), 5);
        compared++;
        if (n_err != err0) begin
            mismatched++;
            $display("FAIL max_no_err: got %0d errors required 0", n_err - err0);
        end
    endtask

    task automatic test_overflow;
        int nt0 = n_nt, ld0 = n_ld, err0 = n_err, dv0 = n_dv;
        logic [127:0] d0 = bus.digest_o;
        for (int i = 0; i < 60; i++) msg[i] = 8'(i + 1);
        send(60);
        compared++;
        if (bus.err_o !== 1'b1) begin
            mismatched++;
            $display("FAIL ovf_err: err_o=%b required 1", bus.err_o);
        end
        tick;
        compared++;
        if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_idle: err=%b busy=%b required 0/0", bus.err_o, bus.busy_o);
        end
        repeat (10) tick;
        compared++;
        if (n_nt != nt0 || n_ld != ld0 || n_err != err0 + 1 || n_dv != dv0) begin
            mismatched++;
            $display("FAIL ovf_activity: nt=%0d ld=%0d err=%0d dv=%0d required 0 0 1 0",
                n_nt - nt0, n_ld - ld0, n_err - err0, n_dv - dv0);
        end
        compared++;
        if (bus.digest_o !== d0) begin
            mismatched++;
            $display("FAIL ovf_digest: got %h required %h", bus.digest_o, d0);
        end
    endtask

    task automatic test_timeout;
        int ld0 = n_ld, dv0 = n_dv, k = 0;
        logic [127:0] d0 = bus.digest_o;
        msg[0] = 8'h78; msg[1] = 8'h79; msg[2] = 8'h7a;
        push_beats(3);
        send(3);
        wait_loads(ld0);
        while (!bus.err_o && k < 300) begin
            tick;
            k++;
        end
        compared++;
        if (k != 127) begin
            mismatched++;
            $display("FAIL timeout_cycles: got %0d required 127", k);
        end
        compared++;
        if (bus.digest_o !== d0 || n_dv != dv0) begin
            mismatched++;
            $display("FAIL timeout_digest: got %h dv=%0d required %h 0", bus.digest_o, n_dv - dv0, d0);
        end
        tick;
        compared++;
        if (bus.err_o !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_err_pulse: err_o=%b required 0", bus.err_o);
        end
    endtask

    task automatic test_back_to_back;
        run_abc();
    endtask

    task automatic test_reset_mid_load;
        int ld0 = n_ld, w = 0;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        push_beats(3);
        send(3);
        while (n_ld < ld0 + 3 && w < 40) begin
            tick;
            w++;
        end
        compared++;
        if (bus.md5_load_o !== 1'b1 || n_ld != ld0 + 3) begin
            mismatched++;
            $display("FAIL beat2_reached: load=%b beats=%0d required 1 3", bus.md5_load_o, n_ld - ld0);
        end
        reset = 1'b0;
        compared++;
        if (beat_q.size() != 1) begin
            mismatched++;
            $display("FAIL beats_left: got %0d required 1", beat_q.size());
        end
        beat_q.delete();
        tick;
        compared++;
        if ({bus.s_ready, bus.md5_newtext_o, bus.md5_load_o, bus.digest_valid_o, bus.err_o, bus.busy_o} !== 6'b0
            || bus.md5_data_o !== '0 || bus.digest_o !== '0) begin
            mismatched++;
            $display("FAIL mid_reset: ctrl=%b data=%h digest=%h required 0",
                {bus.s_ready, bus.md5_newtext_o, bus.md5_load_o, bus.digest_valid_o, bus.err_o, bus.busy_o},
                bus.md5_data_o, bus.digest_o);
        end
        reset = 1'b1;
        tick;
        run_abc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
        bus.s_last      = 1'b0;
        bus.md5_ready_i = 1'b0;
        bus.md5_data_i  = '0;
        test_reset();
        test_abc();
        test_one_byte();
        test_max_len();
        test_overflow();
        test_timeout();
        test_back_to_back();
        test_reset_mid_load();
        repeat (3) tick;
        compared++;
        if (beat_q.size() != 0 || dig_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: beats=%0d digests=%0d left, required 0 0", beat_q.size(), dig_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/md5_pad_loader.md
Name: md5_pad_loader

Overview:
Upstream feeder for the MD5 core in the password authenticator. It collects one password as a byte stream and builds a single 512-bit MD5 block with standard padding. It then drives the core's newtext/load handshake: one newtext pulse followed by four 128-bit load beats. It captures the digest on the core's ready pulse, and flags over-length input and core timeouts.

Parameters:
MAX_LEN, 55, maximum accepted message bytes; legal range 1..55, the single-block limit.
WAIT_TIMEOUT, 127, cycles allowed from the last load beat to core ready before an error is raised.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
s_valid  input  1  upstream byte valid
s_ready  output  1  block can accept a byte
s_data  input  8  password byte, first byte = message byte 0
s_last  input  1  marks final byte of the message
md5_newtext_o  output  1  one-cycle init pulse to core
md5_load_o  output  1  core load strobe
md5_data_o  output  128  load beat to core
md5_ready_i  input  1  core digest-valid pulse
md5_data_i  input  128  core digest, valid only while md5_ready_i=1
digest_o  output  128  captured digest
digest_valid_o  output  1  one-cycle pulse, digest_o updated
err_o  output  1  one-cycle pulse: length overflow or core timeout
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, buffer 0, byte count 0, state IDLE. Reset mid-operation aborts immediately; the core is re-initialised by the next newtext.
- Buffer: 64 bytes. Byte i goes to word k=i/4, lane i%4 (lane 0 = bits [7:0]). Word k occupies block bits [511-32k -: 32]. Beat n = block[511-128n -: 128], so beat 0 = words 0..3.
- Padding, applied when the last byte is accepted at count L:
  - byte L = 0x80;
  - word 14 = 8*L as a 32-bit value;
  - word 15 = 0;
  - all other bytes 0 (buffer cleared on entry to IDLE).
- States:
  - IDLE: s_ready=1. An accepted byte writes index 0, count=1, goes to COLLECT, or directly to PAD if s_last=1.
  - COLLECT: s_ready=1. Each accepted byte writes at the current count and increments it. s_last goes to PAD. Accepting a byte when count=MAX_LEN sets the overflow flag and goes to DRAIN (or straight to ERR if s_last).
  - DRAIN: s_ready=1. Bytes are discarded. s_last goes to ERR.
  - PAD: s_ready=0. Writes padding, one cycle, goes to NEWTEXT.
  - NEWTEXT: md5_newtext_o=1 for exactly one cycle, md5_load_o=0. Goes to LOAD.
  - LOAD: md5_load_o=1 for 4 consecutive cycles, md5_data_o = beat 0,1,2,3 by a 2-bit counter. Goes to WAIT after beat 3. newtext and load are never high together.
  - WAIT: a timer counts cycles. md5_ready_i=1 captures md5_data_i into digest_o, pulses digest_valid_o next cycle, and goes to IDLE. Timer reaching WAIT_TIMEOUT goes to ERR.
  - ERR: err_o=1 for one cycle, digest_o unchanged, goes to IDLE.
- md5_data_o is 0 outside LOAD.
- s_ready is 0 in PAD, NEWTEXT, LOAD, WAIT and ERR.
- md5_ready_i outside WAIT is ignored.
- Latency from the last-byte handshake to digest_valid_o: 1 (PAD) + 1 (NEWTEXT) + 4 (LOAD) + core latency + 1.
- s_valid with s_ready=0 is not consumed; upstream holds the byte.

Optional Feature:
MD5_DIGEST_BYTESWAP_EN
- Defined: digest_o is byte-reversed within each 32-bit word on capture, giving canonical MD5 byte order (digest_o[127:120] = first hex byte).
- Undefined: digest_o = md5_data_i word-for-word, the raw core A,B,C,D little-endian words.

Test Plan:
- Send "abc" (61,62,63, last on 63):
  - beat 0 = 80636261_00000000_00000000_00000000;
  - beat 3 = 00000000_00000000_00000018_00000000;
  - one newtext pulse precedes 4 contiguous loads;
  - core pulse gives digest_o = 98500190_b04fd23c_7d3f96d6_727fe128 (BYTESWAP_EN: 900150983cd24fb0d6963f7d28e17f72).
- Send "a" -> word0 = 00008061, word14 = 00000008; BYTESWAP_EN digest 0cc175b9c0f1b6a831c399e269772661.
- Send 55 bytes of 0x41 -> word13 = 80414141, word14 = 000001B8, no error.
- Send 60 bytes -> 56th byte sets overflow; bytes drained to last; err_o pulses once; no newtext or load issued; digest_valid_o stays 0.
- Hold md5_ready_i=0 after loads -> err_o pulses WAIT_TIMEOUT cycles after beat 3; next message hashes normally.
- Assert reset during LOAD beat 2 -> all outputs 0 next cycle. A following "abc" then produces the correct digest.
